radio_en_sync: RTL and testbench

RADIO_EN_SYNC -- requirements
Module: radio_en_sync

---
 rtl/radio_en_sync.sv | 152 +++++++++++++++
 tb/tb_radio_en_sync.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/radio_en_sync.sv
// Per-lane synchronizer + debouncer for radio enable/rx requests, with an
// isolation clamp on the registered outputs and enable edge pulses.

// state     | meaning
// LOW       | debounced level 0, input agrees
// QUAL_HIGH | debounced level 0, counting consecutive 1 samples
// HIGH      | debounced level 1, input agrees
// QUAL_LOW  | debounced level 1, counting consecutive 0 samples
module radio_en_sync_deb #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic ck,
  input  logic arst_n,
  input  logic din,
  output logic lvl_d
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {LOW, QUAL_HIGH, HIGH, QUAL_LOW} st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      st_q  <= LOW;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // The counter is 0 in the settled states, so the first disagreeing sample
  // yields 1 and a one-cycle qualification goes straight to the far state.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    case (st_q)
      LOW, QUAL_HIGH: begin
        if (din) begin
          if (cnt_inc == DC) begin
            st_d  = HIGH;
            cnt_d = '0;
          end else begin
            st_d  = QUAL_HIGH;
            cnt_d = cnt_inc;
          end
        end else begin
          st_d  = LOW;
          cnt_d = '0;
        end
      end
      HIGH, QUAL_LOW: begin
        if (!din) begin
          if (cnt_inc == DC) begin
            st_d  = LOW;
            cnt_d = '0;
          end else begin
            st_d  = QUAL_LOW;
            cnt_d = cnt_inc;
          end
        end else begin
          st_d  = HIGH;
          cnt_d = '0;
        end
      end
      default: begin
        st_d  = LOW;
        cnt_d = '0;
      end
    endcase
  end

  assign lvl_d = (st_d == HIGH) || (st_d == QUAL_LOW);
endmodule

module radio_en_sync #(
  parameter int BIT_WIDTH       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 ck,
  input  logic                 arst_n,
  input  logic [BIT_WIDTH-1:0] radioEnableAsync,
  input  logic [BIT_WIDTH-1:0] radioRxEnAsync,
  input  logic                 isolateM1M2,
  output logic [BIT_WIDTH-1:0] radioEnableSynced,
  output logic [BIT_WIDTH-1:0] radioRxEnSynced,
  output logic [BIT_WIDTH-1:0] enRisePulse,
  output logic [BIT_WIDTH-1:0] enFallPulse
);
  logic [BIT_WIDTH-1:0] en_lvl_d, rx_lvl_d;
  logic [BIT_WIDTH-1:0] en_raw_q, rx_raw_q;

  for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_lane
    logic [SYNC_STAGES-1:0] en_sr, rx_sr;

    always_ff @(posedge ck or negedge arst_n) begin
      if (!arst_n) begin
        en_sr <= '0;
        rx_sr <= '0;
      end else begin
        en_sr <= {en_sr[SYNC_STAGES-2:0], radioEnableAsync[g]};
        rx_sr <= {rx_sr[SYNC_STAGES-2:0], radioRxEnAsync[g]};
      end
    end

    radio_en_sync_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_deb (
      .ck    (ck),
      .arst_n(arst_n),
      .din   (en_sr[SYNC_STAGES-1]),
      .lvl_d (en_lvl_d[g])
    );

    radio_en_sync_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rx_deb (
      .ck    (ck),
      .arst_n(arst_n),
      .din   (rx_sr[SYNC_STAGES-1]),
      .lvl_d (rx_lvl_d[g])
    );
  end

  // rx rises one edge after both levels are up (en_raw_q), but drops on the
  // same edge the enable drops (en_lvl_d), so rx never outlives the enable.
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      en_raw_q          <= '0;
      rx_raw_q          <= '0;
      radioEnableSynced <= '0;
      radioRxEnSynced   <= '0;
      enRisePulse       <= '0;
      enFallPulse       <= '0;
    end else begin
      en_raw_q <= en_lvl_d;
      rx_raw_q <= rx_lvl_d;
      if (isolateM1M2) begin
        radioEnableSynced <= '0;
        radioRxEnSynced   <= '0;
        enRisePulse       <= '0;
        enFallPulse       <= '0;
      end else begin
        radioEnableSynced <= en_lvl_d;
        radioRxEnSynced   <= rx_raw_q & en_raw_q & en_lvl_d;
        enRisePulse       <= en_lvl_d & ~en_raw_q;
        enFallPulse       <= ~en_lvl_d & en_raw_q;
      end
    end
  end
endmodule

// File: tb/tb_radio_en_sync.sv
// Directed bench for radio_en_sync: default-parameter vector table plus
// reset and 4-lane/1-cycle-debounce sequences.
module tb_radio_en_sync;
  logic ck = 1'b0;
  logic arst_n;
  always #5 ck = ~ck;

  logic [1:0] en, rx, en_o, rx_o, rise_o, fall_o;
  logic       iso;
  logic [3:0] en2, rx2, en2_o, rx2_o, rise2_o, fall2_o;
  logic       iso2;

  radio_en_sync u_dut (
    .ck(ck), .arst_n(arst_n), .radioEnableAsync(en), .radioRxEnAsync(rx),
    .isolateM1M2(iso), .radioEnableSynced(en_o), .radioRxEnSynced(rx_o),
    .enRisePulse(rise_o), .enFallPulse(fall_o)
  );

  radio_en_sync #(.BIT_WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut2 (
    .ck(ck), .arst_n(arst_n), .radioEnableAsync(en2), .radioRxEnAsync(rx2),
    .isolateM1M2(iso2), .radioEnableSynced(en2_o), .radioRxEnSynced(rx2_o),
    .enRisePulse(rise2_o), .enFallPulse(fall2_o)
  );

  typedef struct {
    logic [1:0] en;
    logic [1:0] rx;
    logic       iso;
    logic [1:0] x_en;
    logic [1:0] x_rx;
    logic [1:0] x_rise;
    logic [1:0] x_fall;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_n(input int n, input logic [1:0] e, input logic [1:0] r,
                        input logic i, input logic [1:0] xe, input logic [1:0] xr,
                        input logic [1:0] xri, input logic [1:0] xf, input string tag);
    vec_t v;
    v.en = e; v.rx = r; v.iso = i; v.x_en = xe; v.x_rx = xr;
    v.x_rise = xri; v.x_fall = xf; v.tag = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string tag, input logic [1:0] xe, input logic [1:0] xr,
                        input logic [1:0] xri, input logic [1:0] xf);
    cmp({tag, " en"},   {2'b00, en_o},   {2'b00, xe});
    cmp({tag, " rx"},   {2'b00, rx_o},   {2'b00, xr});
    cmp({tag, " rise"}, {2'b00, rise_o}, {2'b00, xri});
    cmp({tag, " fall"}, {2'b00, fall_o}, {2'b00, xf});
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic lvl2(input int j);
    if (j < 1) return 1'b0;
    return (((j - 1) / 8) % 2) == 0;
  endfunction

  initial begin
    // lane-0 enable rise; lane 1 untouched
    push_n(5, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, "p1_wait");
    push_n(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, "p1_edge6");
    push_n(1, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, "p1_edge7");
    // both lanes en+rx high: lane-1 enable at edge 6, rx at edge 7
    push_n(5, 2'b11, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b00, "p2_wait");
    push_n(1, 2'b11, 2'b11, 0, 2'b11, 2'b00, 2'b10, 2'b00, "p2_edge6");
    push_n(1, 2'b11, 2'b11, 0, 2'b11, 2'b11, 2'b00, 2'b00, "p2_edge7");
    // drop lane-1 enable with rx held: rx falls with enable
    push_n(5, 2'b01, 2'b11, 0, 2'b11, 2'b11, 2'b00, 2'b00, "p3_wait");
    push_n(1, 2'b01, 2'b11, 0, 2'b01, 2'b01, 2'b00, 2'b10, "p3_edge6");
    push_n(1, 2'b01, 2'b11, 0, 2'b01, 2'b01, 2'b00, 2'b00, "p3_edge7");
    // 3-cycle glitch on lane-1 enable
    push_n(3, 2'b11, 2'b11, 0, 2'b01, 2'b01, 2'b00, 2'b00, "p4_glitch");
    push_n(6, 2'b01, 2'b11, 0, 2'b01, 2'b01, 2'b00, 2'b00, "p4_after");
    // isolation with lane-0 enable dropped inside
    push_n(2, 2'b01, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, "p5_iso");
    push_n(8, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, "p5_iso_drop");
    push_n(3, 2'b00, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, "p5_release");
    // lane-1 enable up again ahead of the reset sequence
    push_n(5, 2'b10, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, "p6_wait");
    push_n(1, 2'b10, 2'b11, 0, 2'b10, 2'b00, 2'b10, 2'b00, "p6_edge6");
    push_n(1, 2'b10, 2'b11, 0, 2'b10, 2'b10, 2'b00, 2'b00, "p6_edge7");

    arst_n = 1'b0;
    en = '0; rx = '0; iso = 1'b0;
    en2 = '0; rx2 = '0; iso2 = 1'b0;
    #2;
    check1("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    cmp("reset dut2 en", en2_o, 4'h0);
    tick();
    tick();
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en; rx = vecs[i].rx; iso = vecs[i].iso;
      tick();
      check1(vecs[i].tag, vecs[i].x_en, vecs[i].x_rx, vecs[i].x_rise, vecs[i].x_fall);
    end

    // reset while lane 0 is mid-qualification (count 3)
    en = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check1("rst_qual", 2'b10, 2'b10, 2'b00, 2'b00);
    end
    #2 arst_n = 1'b0;
    #1 check1("rst_entry", 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    check1("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
    arst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check1("rst_exit_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    tick();
    check1("rst_exit_edge6", 2'b11, 2'b00, 2'b11, 2'b00);
    tick();
    check1("rst_exit_edge7", 2'b11, 2'b11, 2'b00, 2'b00);

    // 4 lanes, 3 sync stages, 1-cycle debounce, toggle every 8 cycles
    for (int k = 1; k <= 40; k++) begin
      logic cur, prv;
      en2 = lvl2(k) ? 4'hF : 4'h0;
      rx2 = en2;
      tick();
      cur = lvl2(k - 3);
      prv = lvl2(k - 4);
      cmp("w4 en",   en2_o,   {4{cur}});
      cmp("w4 rx",   rx2_o,   {4{cur & prv}});
      cmp("w4 rise", rise2_o, {4{cur & ~prv}});
      cmp("w4 fall", fall2_o, {4{~cur & prv}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
